// File: rtl/utils_pkg.sv
// utils: shared types, physics constants and level collision map for the
// player update pipeline.
//   vec2d    - signed 16.16 fixed-point 2D vector (speed, sub-pixel remainder)
//   vec2dint - unsigned integer pixel position
//   is_solid - tile map query for one pixel
//   collides - 8x8 player hitbox query (columns x+1..x+6, rows y..y+7)
package utils;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vec2d;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vec2dint;

  typedef enum logic [1:0] {S_IDLE, S_SPEED, S_MOVE} state_e;

  localparam logic [15:0] SPAWN_X = 16'd8;
  localparam logic [15:0] SPAWN_Y = 16'd96;

  // Button bit positions in btn_i
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_JUMP  = 4;
  localparam int BTN_DASH  = 5;

  // Physics, all 16.16 signed
  localparam logic signed [31:0] RUN_MAX   = 32'sh0001_0000;
  localparam logic signed [31:0] ACCEL_GND = 32'sh0000_9999;
  localparam logic signed [31:0] ACCEL_AIR = 32'sh0000_6666;
  localparam logic signed [31:0] DECEL     = 32'sh0000_2666;
  localparam logic signed [31:0] GRAVITY   = 32'sh0000_35C3;
  localparam logic signed [31:0] MAXFALL   = 32'sh0002_0000;
  localparam logic signed [31:0] JUMP_SPD  = 32'shFFFE_0000;
  localparam logic signed [31:0] DASH_CARD = 32'sh0005_0000;
  localparam logic signed [31:0] DASH_DIAG = 32'sh0003_8918;

  localparam logic [2:0] GRACE_LEN = 3'd6;
  localparam logic [2:0] JBUF_LEN  = 3'd4;
  localparam logic [2:0] DASH_LEN  = 3'd4;

  // Level: a ledge (x<24) whose top is row 120, and a floor at row 160
  localparam logic [15:0] LEDGE_Y     = 16'd120;
  localparam logic [15:0] LEDGE_X_END = 16'd24;
  localparam logic [15:0] FLOOR_Y     = 16'd160;

  function automatic logic is_solid(input logic [15:0] x, input logic [15:0] y);
    return (y >= FLOOR_Y) || ((y >= LEDGE_Y) && (x < LEDGE_X_END));
  endfunction

  function automatic logic collides(input vec2dint p);
    return is_solid(p.x + 16'd1, p.y)         || is_solid(p.x + 16'd6, p.y) ||
           is_solid(p.x + 16'd1, p.y + 16'd7) || is_solid(p.x + 16'd6, p.y + 16'd7);
  endfunction

endpackage

// File: rtl/player_move.sv
// player_move: combinational pixel-stepping mover.
//   pos_i/rem_i/spd_i - current position, sub-pixel remainder, speed
//   pos_o/rem_o/spd_o - moved position, new remainder, speed (axis zeroed on hit)
// X is resolved first, then Y from the updated X. Each axis steps one pixel
// at a time and stops at the first colliding pixel.
module player_move
  import utils::*;
#(
  parameter int MAX_STEPS = 8
) (
  input  vec2dint pos_i,
  input  vec2d    rem_i,
  input  vec2d    spd_i,
  output vec2dint pos_o,
  output vec2d    rem_o,
  output vec2d    spd_o
);

  logic signed [31:0] tot_x, tot_y;
  logic signed [15:0] n_x, n_y;
  logic [15:0]        abs_x, abs_y;
  logic               blk_x, blk_y;
  vec2dint            cur, cand;

  always_comb begin
    cur   = pos_i;
    cand  = pos_i;
    spd_o = spd_i;
    rem_o = '0;
    // Integer part (floor) is the pixel count, fraction stays as remainder
    tot_x = rem_i.x + spd_i.x;
    n_x   = tot_x[31:16];
    abs_x = n_x[15] ? 16'(-n_x) : 16'(n_x);
    blk_x = 1'b0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      if (!blk_x && (16'(i) < abs_x)) begin
        cand   = cur;
        cand.x = n_x[15] ? cur.x - 16'd1 : cur.x + 16'd1;
        if (collides(cand)) blk_x = 1'b1;
        else                cur   = cand;
      end
    end
    if (blk_x) spd_o.x = '0;
    else       rem_o.x = {16'd0, tot_x[15:0]};

    tot_y = rem_i.y + spd_i.y;
    n_y   = tot_y[31:16];
    abs_y = n_y[15] ? 16'(-n_y) : 16'(n_y);
    blk_y = 1'b0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      if (!blk_y && (16'(i) < abs_y)) begin
        cand   = cur;
        cand.y = n_y[15] ? cur.y - 16'd1 : cur.y + 16'd1;
        if (collides(cand)) blk_y = 1'b1;
        else                cur   = cand;
      end
    end
    if (blk_y) spd_o.y = '0;
    else       rem_o.y = {16'd0, tot_y[15:0]};

    pos_o = cur;
  end

endmodule

// File: rtl/player_update.sv
// player_update: per-frame player physics (run, gravity, coyote jump, jump
// buffer, 8-way dash) followed by a collision-resolving move.
//   clk_i, rst_i (async, active high), frame_tick_i (frame start pulse)
//   btn_i        {dash,jump,down,up,right,left}, latched on frame_tick_i
//   pos_o/spd_o/rem_o  committed position, speed, sub-pixel remainder
//   dashing_o, dash_avail_o, frame_done_o (commit pulse), overrun_o (sticky)
// Frame: IDLE -tick-> SPEED (speed + counters) -> MOVE (commit) -> IDLE.
module player_update
  import utils::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic [5:0] btn_i,
  output vec2dint    pos_o,
  output vec2d       spd_o,
  output vec2d       rem_o,
  output logic       dashing_o,
  output logic       dash_avail_o,
  output logic       frame_done_o,
  output logic       overrun_o
);

  state_e     state_q, state_d;
  logic [5:0] btn_q;
  vec2dint    pos_q, mv_pos;
  vec2d       spd_q, rem_q, spd_new_q, spd_d, mv_rem, mv_spd;
  logic [2:0] grace_q, grace_d, jbuf_q, jbuf_d, dash_tmr_q, dash_tmr_d;
  logic       dash_avail_q, dash_avail_d, facing_q, facing_d;
  logic       jump_prev_q, dash_prev_q, frame_done_q, overrun_q;

  logic left, right, up, down, jump_press, dash_press, dashing, grounded;
  logic dl, dr, du, dd, over;
  logic signed [31:0] sx, sy, target, step, mag;

  assign left       = btn_q[BTN_LEFT];
  assign right      = btn_q[BTN_RIGHT];
  assign up         = btn_q[BTN_UP];
  assign down       = btn_q[BTN_DOWN];
  assign jump_press = btn_q[BTN_JUMP] & ~jump_prev_q;
  assign dash_press = btn_q[BTN_DASH] & ~dash_prev_q;
  assign dashing    = (dash_tmr_q != 3'd0);
  assign grounded   = is_solid(pos_q.x + 16'd1, pos_q.y + 16'd8) ||
                      is_solid(pos_q.x + 16'd6, pos_q.y + 16'd8);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_tick_i) state_d = S_SPEED;
      S_SPEED: state_d = S_MOVE;
      S_MOVE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sx           = spd_q.x;
    sy           = spd_q.y;
    spd_d        = spd_q;
    grace_d      = grounded ? GRACE_LEN : ((grace_q != 3'd0) ? grace_q - 3'd1 : 3'd0);
    jbuf_d       = jump_press ? JBUF_LEN : ((jbuf_q != 3'd0) ? jbuf_q - 3'd1 : 3'd0);
    dash_tmr_d   = dash_tmr_q;
    dash_avail_d = dash_avail_q;
    facing_d     = (left ^ right) ? right : facing_q;
    dl           = left & ~right;
    dr           = right & ~left;
    du           = up & ~down;
    dd           = down & ~up;
    target       = '0;
    step         = '0;
    mag          = '0;
    over         = 1'b0;
    if (dash_press && dash_avail_q && !dashing) begin
      // No direction held: dash horizontally the way we face
      if (!(dl | dr | du | dd)) begin
        dr = facing_q;
        dl = ~facing_q;
      end
      mag        = ((dl | dr) && (du | dd)) ? DASH_DIAG : DASH_CARD;
      spd_d.x    = dr ? mag : (dl ? -mag : 32'sd0);
      spd_d.y    = dd ? mag : (du ? -mag : 32'sd0);
      dash_tmr_d = DASH_LEN;
      dash_avail_d = 1'b0;
    end else if (dashing) begin
      dash_tmr_d = dash_tmr_q - 3'd1;
    end else begin
      target = dr ? RUN_MAX : (dl ? -RUN_MAX : 32'sd0);
      // Above run speed in the held direction: bleed off slowly
      over   = (dr && (sx > RUN_MAX)) || (dl && (sx < -RUN_MAX));
      step   = over ? DECEL : (grounded ? ACCEL_GND : ACCEL_AIR);
      if (sx < target)      spd_d.x = (sx + step > target) ? target : sx + step;
      else if (sx > target) spd_d.x = (sx - step < target) ? target : sx - step;
      if (!grounded) spd_d.y = (sy + GRAVITY > MAXFALL) ? MAXFALL : sy + GRAVITY;
      if ((jbuf_d != 3'd0) && (grace_d != 3'd0)) begin
        spd_d.y = JUMP_SPD;
        jbuf_d  = 3'd0;
        grace_d = 3'd0;
      end
    end
    if (grounded && (dash_tmr_d == 3'd0)) dash_avail_d = 1'b1;
  end

  player_move u_move (
    .pos_i (pos_q),
    .rem_i (rem_q),
    .spd_i (spd_new_q),
    .pos_o (mv_pos),
    .rem_o (mv_rem),
    .spd_o (mv_spd)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      btn_q        <= '0;
      pos_q        <= {SPAWN_X, SPAWN_Y};
      spd_q        <= '0;
      rem_q        <= '0;
      spd_new_q    <= '0;
      grace_q      <= '0;
      jbuf_q       <= '0;
      dash_tmr_q   <= '0;
      dash_avail_q <= 1'b1;
      facing_q     <= 1'b1;
      jump_prev_q  <= 1'b0;
      dash_prev_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= 1'b0;
      if (frame_tick_i && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: if (frame_tick_i) btn_q <= btn_i;
        S_SPEED: begin
          spd_new_q    <= spd_d;
          grace_q      <= grace_d;
          jbuf_q       <= jbuf_d;
          dash_tmr_q   <= dash_tmr_d;
          dash_avail_q <= dash_avail_d;
          facing_q     <= facing_d;
          jump_prev_q  <= btn_q[BTN_JUMP];
          dash_prev_q  <= btn_q[BTN_DASH];
        end
        S_MOVE: begin
          pos_q        <= mv_pos;
          rem_q        <= mv_rem;
          spd_q        <= mv_spd;
          frame_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pos_o        = pos_q;
  assign spd_o        = spd_q;
  assign rem_o        = rem_q;
  assign dashing_o    = dashing;
  assign dash_avail_o = dash_avail_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_player_update.sv
module tb_player_update;
  import utils::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic [5:0] btn_i = '0;
  vec2dint    pos_o;
  vec2d       spd_o, rem_o;
  logic       dashing_o, dash_avail_o, frame_done_o, overrun_o;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_RIGHT = 6'b000010;
  localparam logic [5:0] B_JUMP  = 6'b010000;
  localparam logic [5:0] B_RJUMP = 6'b010010;
  localparam logic [5:0] B_DASH  = 6'b100000;
  localparam logic [5:0] B_DUR   = 6'b100110;

  player_update dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_tick_i(frame_tick_i), .btn_i(btn_i),
    .pos_o(pos_o), .spd_o(spd_o), .rem_o(rem_o), .dashing_o(dashing_o),
    .dash_avail_o(dash_avail_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    rst_i = 1'b1;
    frame_tick_i = 1'b0;
    btn_i = B_NONE;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // One frame: tick at a negedge, done pulse expected two posedges later.
  task automatic frame(input logic [5:0] b);
    btn_i = b;
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b0) begin failures++; $display("FAIL frame_done_early got=%b exp=0", frame_done_o); end
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b1) begin failures++; $display("FAIL frame_done_tick+2 got=%b exp=1", frame_done_o); end
  endtask

  // Spawn, fall and come to rest on the ledge at (8,112).
  task automatic settle();
    do_reset();
    repeat (30) frame(B_NONE);
    checks++;
    if (pos_o !== {16'd8, 16'd112}) begin failures++; $display("FAIL settle_pos got=(%0d,%0d) exp=(8,112)", pos_o.x, pos_o.y); end
    checks++;
    if (spd_o !== 64'd0) begin failures++; $display("FAIL settle_spd got=%h exp=0", spd_o); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pos_o !== {16'd8, 16'd96}) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(8,96)", pos_o.x, pos_o.y); end
    checks++;
    if (spd_o !== 64'd0) begin failures++; $display("FAIL reset_spd got=%h exp=0", spd_o); end
    checks++;
    if (rem_o !== 64'd0) begin failures++; $display("FAIL reset_rem got=%h exp=0", rem_o); end
    checks++;
    if ({dashing_o, dash_avail_o, frame_done_o, overrun_o} !== 4'b0100) begin
      failures++; $display("FAIL reset_flags got=%b exp=0100", {dashing_o, dash_avail_o, frame_done_o, overrun_o});
    end
  endtask

  // Free fall from spawn, jump pressed mid-air, buffered jump on landing.
  task automatic test_gravity_buffer();
    frame(B_NONE);
    checks++;
    if (spd_o.y !== 32'h000035C3) begin failures++; $display("FAIL grav_f1 got=%h exp=000035c3", spd_o.y); end
    frame(B_NONE);
    checks++;
    if (spd_o.y !== 32'h00006B86) begin failures++; $display("FAIL grav_f2 got=%h exp=00006b86", spd_o.y); end
    frame(B_NONE);
    checks++;
    if (spd_o.y !== 32'h0000A149) begin failures++; $display("FAIL grav_f3 got=%h exp=0000a149", spd_o.y); end
    checks++;
    if (pos_o.y !== 16'd97 || rem_o.y !== 32'h00004292) begin
      failures++; $display("FAIL grav_f3_pos got=%0d/%h exp=97/00004292", pos_o.y, rem_o.y);
    end
    repeat (7) frame(B_NONE);
    frame(B_JUMP);
    checks++;
    if (spd_o.y !== 32'h00020000) begin failures++; $display("FAIL grav_clamp got=%h exp=00020000", spd_o.y); end
    checks++;
    if (dut.jbuf_q !== 3'd4 || dut.grace_q !== 3'd0) begin
      failures++; $display("FAIL buf_armed got=%0d/%0d exp=4/0", dut.jbuf_q, dut.grace_q);
    end
    frame(B_NONE);
    frame(B_NONE);
    checks++;
    if (pos_o.y !== 16'd112 || spd_o.y !== 32'd0 || rem_o.y !== 32'd0) begin
      failures++; $display("FAIL land got=%0d/%h/%h exp=112/0/0", pos_o.y, spd_o.y, rem_o.y);
    end
    frame(B_NONE);
    checks++;
    if (spd_o.y !== 32'hFFFE0000 || pos_o.y !== 16'd110) begin
      failures++; $display("FAIL buffered_jump got=%h/%0d exp=fffe0000/110", spd_o.y, pos_o.y);
    end
  endtask

  task automatic test_jump();
    settle();
    frame(B_JUMP);
    checks++;
    if (spd_o.y !== 32'hFFFE0000 || pos_o.y !== 16'd110) begin
      failures++; $display("FAIL jump got=%h/%0d exp=fffe0000/110", spd_o.y, pos_o.y);
    end
    checks++;
    if (dut.grace_q !== 3'd0 || dut.jbuf_q !== 3'd0) begin
      failures++; $display("FAIL jump_counters got=%0d/%0d exp=0/0", dut.grace_q, dut.jbuf_q);
    end
    frame(B_JUMP);
    checks++;
    if (spd_o.y !== 32'hFFFE35C3 || dut.jbuf_q !== 3'd0) begin
      failures++; $display("FAIL jump_held got=%h/%0d exp=fffe35c3/0", spd_o.y, dut.jbuf_q);
    end
  endtask

  task automatic test_coyote();
    settle();
    repeat (16) frame(B_RIGHT);
    checks++;
    if (pos_o !== {16'd23, 16'd112} || spd_o.x !== 32'h00010000) begin
      failures++; $display("FAIL walk got=(%0d,%0d)/%h exp=(23,112)/00010000", pos_o.x, pos_o.y, spd_o.x);
    end
    frame(B_RIGHT);
    checks++;
    if (dut.grace_q !== 3'd5 || spd_o.y !== 32'h000035C3) begin
      failures++; $display("FAIL ledge_off got=%0d/%h exp=5/000035c3", dut.grace_q, spd_o.y);
    end
    frame(B_RIGHT);
    frame(B_RJUMP);
    checks++;
    if (spd_o.y !== 32'hFFFE0000 || dut.grace_q !== 3'd0 || dut.jbuf_q !== 3'd0) begin
      failures++; $display("FAIL coyote_jump got=%h/%0d/%0d exp=fffe0000/0/0", spd_o.y, dut.grace_q, dut.jbuf_q);
    end
  endtask

  task automatic test_no_coyote();
    settle();
    repeat (22) frame(B_RIGHT);
    frame(B_RJUMP);
    checks++;
    if (spd_o.y !== 32'h00017855 || dut.jbuf_q !== 3'd4 || dut.grace_q !== 3'd0) begin
      failures++; $display("FAIL late_jump got=%h/%0d/%0d exp=00017855/4/0", spd_o.y, dut.jbuf_q, dut.grace_q);
    end
  endtask

  task automatic test_dash();
    settle();
    for (int f = 1; f <= 4; f++) begin
      frame(B_DUR);
      checks++;
      if (spd_o !== {32'h00038918, 32'hFFFC76E8}) begin
        failures++; $display("FAIL dash_spd f%0d got=%h exp=00038918fffc76e8", f, spd_o);
      end
      checks++;
      if (dashing_o !== 1'b1 || dash_avail_o !== 1'b0) begin
        failures++; $display("FAIL dash_flags f%0d got=%b%b exp=10", f, dashing_o, dash_avail_o);
      end
    end
    frame(B_NONE);
    checks++;
    if (dashing_o !== 1'b0) begin failures++; $display("FAIL dash_end got=%b exp=0", dashing_o); end
    frame(B_DASH);
    checks++;
    if (dashing_o !== 1'b0 || dash_avail_o !== 1'b0) begin
      failures++; $display("FAIL air_dash got=%b%b exp=00", dashing_o, dash_avail_o);
    end
    repeat (100) frame(B_NONE);
    checks++;
    if (dash_avail_o !== 1'b1 || pos_o.y !== 16'd152 || spd_o.y !== 32'd0) begin
      failures++; $display("FAIL dash_restore got=%b/%0d/%h exp=1/152/0", dash_avail_o, pos_o.y, spd_o.y);
    end
  endtask

  task automatic test_overrun();
    settle();
    btn_i = B_NONE;
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    checks++;
    if (frame_done_o !== 1'b0 || overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_set got=%b%b exp=01", frame_done_o, overrun_o);
    end
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b1) begin failures++; $display("FAIL overrun_done got=%b exp=1", frame_done_o); end
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b0) begin failures++; $display("FAIL overrun_single1 got=%b exp=0", frame_done_o); end
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b0) begin failures++; $display("FAIL overrun_single2 got=%b exp=0", frame_done_o); end
    frame(B_NONE);
    checks++;
    if (overrun_o !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun_o); end
  endtask

  task automatic test_reset_mid();
    btn_i = B_NONE;
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (pos_o !== {16'd8, 16'd96}) begin failures++; $display("FAIL mid_rst_pos got=(%0d,%0d) exp=(8,96)", pos_o.x, pos_o.y); end
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if (frame_done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_done1 got=%b exp=0", frame_done_o); end
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b0 || pos_o !== {16'd8, 16'd96} || overrun_o !== 1'b0) begin
      failures++; $display("FAIL mid_rst_after got=%b/(%0d,%0d)/%b exp=0/(8,96)/0", frame_done_o, pos_o.x, pos_o.y, overrun_o);
    end
    frame(B_NONE);
    checks++;
    if (spd_o.y !== 32'h000035C3) begin failures++; $display("FAIL mid_rst_resume got=%h exp=000035c3", spd_o.y); end
  endtask

  initial begin
    test_reset();
    test_gravity_buffer();
    test_jump();
    test_coyote();
    test_no_coyote();
    test_dash();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
